// File: rtl/q2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : q2_pkg
//  Purpose  : Shared definitions for the Q2 serial-CPU sequencer: the
//             sequencer state encoding and the 3-bit instruction opcodes.
//  Revision : 1.0  initial release
// ============================================================================
package q2_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DEREF = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ALU   = 3'd3,
        ST_EXEC  = 3'd4
    } state_t;

    // op[2]=0 : operand load followed by a serial ALU pass
    // op[2]=1 : executed directly in EXEC
    localparam logic [2:0] OP_LD  = 3'b000;
    localparam logic [2:0] OP_NOR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_RSV = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JNF = 3'b111;

endpackage
`default_nettype wire

// File: rtl/q2_bitcnt.sv
`default_nettype none
// ============================================================================
//  Module   : q2_bitcnt
//  Purpose  : Serial bit counter 0..WIDTH-1 with terminal-count flag.
//  Ports    : clk, rst_n (sync, active low)
//             clr  - force count to 0
//             en   - advance; wraps to 0 after WIDTH-1
//             cnt  - current bit index
//             tc   - count is at WIDTH-1
//  Revision : 1.0  initial release
// ============================================================================
module q2_bitcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/q2_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : q2_sequencer
//  Purpose  : Control sequencer of the Q2 bit-serial CPU. Walks each
//             instruction through FETCH / DEREF / LOAD / ALU / EXEC and
//             issues the memory request, source selects and write strobes.
//  Ports    : clk, rst_n (sync, active low)
//             ins_op, ins_deref   - instruction fields (latched on fetch ack)
//             f, x0, alu_cout     - flag / X LSB / serial carry for fout, jnf
//             mem_ack             - completes an access while mem_req is high
//             mem_req, rdp/rdm/rda, wro/wrx/wra/wrp/wrm/wrf, incp,
//             shift_en, fout, busy, state, bit_cnt - all forced to 0 in reset
//  Options  : Q2_SEQ_STEP_EN adds inputs run/step. With run=0, FETCH waits
//             for a rising edge on step and then runs one instruction.
//  Revision : 1.0  initial release
// ============================================================================
module q2_sequencer
    import q2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef Q2_SEQ_STEP_EN
    input  logic             run,
    input  logic             step,
`endif
    input  logic [2:0]       ins_op,
    input  logic             ins_deref,
    input  logic             f,
    input  logic             x0,
    input  logic             alu_cout,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             rdp,
    output logic             rdm,
    output logic             rda,
    output logic             wro,
    output logic             wrx,
    output logic             wra,
    output logic             wrp,
    output logic             wrm,
    output logic             wrf,
    output logic             incp,
    output logic             shift_en,
    output logic             fout,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic             r_deref;
    logic             w_go;
    logic             w_req;
    logic             w_ack;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_cnt;

`ifdef Q2_SEQ_STEP_EN
    logic r_step_q;
    logic r_armed;
    logic w_rise;

    assign w_rise = step & ~r_step_q;
    // Armed holds a step request across a delayed fetch acknowledge.
    assign w_go   = run | r_armed | w_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_step_q <= step;
            r_armed  <= (r_state == ST_FETCH) & ~run & (r_armed | w_rise) & ~w_ack;
        end
    end
`else
    assign w_go = 1'b1;
`endif

    // Request is computed separately so the acknowledge can feed the
    // strobe/next-state logic without a combinational self-reference.
    always_comb begin
        w_req = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: w_req = w_go;
                ST_DEREF: w_req = 1'b1;
                ST_LOAD:  w_req = 1'b1;
                ST_EXEC:  w_req = (r_op == OP_ST);
                default:  w_req = 1'b0;
            endcase
        end
    end

    assign w_ack = w_req & mem_ack;

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        mem_req   = w_req;
        rdp       = 1'b0;
        rdm       = 1'b0;
        rda       = 1'b0;
        wro       = 1'b0;
        wrx       = 1'b0;
        wra       = 1'b0;
        wrp       = 1'b0;
        wrm       = 1'b0;
        wrf       = 1'b0;
        incp      = 1'b0;
        shift_en  = 1'b0;
        fout      = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    rdp = w_go;
                    if (w_ack) begin
                        wro  = 1'b1;
                        incp = 1'b1;
                        // Decode from the bus: the op register loads on this edge.
                        if (ins_deref)      w_next = ST_DEREF;
                        else if (ins_op[2]) w_next = ST_EXEC;
                        else                w_next = ST_LOAD;
                    end
                end
                ST_DEREF: begin
                    rdm = 1'b1;
                    if (w_ack) begin
                        wrx    = r_deref;
                        w_next = r_op[2] ? ST_EXEC : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rdm = 1'b1;
                    if (w_ack) begin
                        wrx       = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = ST_ALU;
                    end
                end
                ST_ALU: begin
                    shift_en = 1'b1;
                    wra      = 1'b1;
                    w_cnt_en = 1'b1;
                    if (w_tc) begin
                        wrf    = 1'b1;
                        w_next = ST_FETCH;
                        case (r_op)
                            OP_LD, OP_NOR: fout = 1'b1;
                            OP_ADD:        fout = alu_cout;
                            OP_SHR:        fout = x0;
                            default:       fout = 1'b0;
                        endcase
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_ST: begin
                            rda = 1'b1;
                            if (w_ack) begin
                                wrm    = 1'b1;
                                w_next = ST_FETCH;
                            end
                        end
                        OP_JMP: begin
                            wrp    = 1'b1;
                            w_next = ST_FETCH;
                        end
                        OP_JNF: begin
                            wrp    = ~f;
                            w_next = ST_FETCH;
                        end
                        OP_RSV:  w_next = ST_FETCH;
                        default: w_next = ST_FETCH;
                    endcase
                end
                default: w_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_op    <= OP_LD;
            r_deref <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_FETCH) && w_ack) begin
                r_op    <= ins_op;
                r_deref <= ins_deref;
            end
        end
    end

    q2_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .cnt   (w_cnt),
        .tc    (w_tc)
    );

    assign state   = rst_n ? r_state : 3'd0;
    assign bit_cnt = rst_n ? w_cnt : '0;
    assign busy    = rst_n & (r_state != ST_FETCH);

endmodule
`default_nettype wire

// File: doc/q2_sequencer.md
Q2_SEQUENCER -- requirements
Module: q2_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the serial datapath word length in bits (legal 2..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH), meaning the bit-counter width.
REQ-003 SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  sync active-low reset
  ins_op  in  3  opcode field from the instruction bus
  ins_deref  in  1  indirect bit from the instruction bus
  f  in  1  current flag
  x0  in  1  X register LSB
  alu_cout  in  1  serial ALU carry
  mem_ack  in  1  memory access complete
  mem_req  out  1  memory access request
  state  out  3  current state code
  bit_cnt  out  CNT_W  serial bit index
  rdp/rdm/rda  out  1 each  address/data source select: P, memory, A
  wro/wrx/wra/wrp/wrm/wrf  out  1 each  write strobes
  incp  out  1  increment P
  shift_en  out  1  serial shift of A and X
  fout  out  1  flag value to write
  busy  out  1  state is not FETCH

Function
REQ-010 SHALL implement the states FETCH=0, DEREF=1, LOAD=2, ALU=3 and EXEC=4.
REQ-011 SHALL complete a memory access in any cycle where mem_req and mem_ack are both high at the clock edge; ack in the first cycle of the state is allowed; mem_ack with mem_req low is ignored.
REQ-012 FETCH SHALL assert mem_req and rdp; on ack it SHALL pulse wro and incp and latch ins_op and ins_deref into internal op/deref registers; next state is DEREF if deref=1, else LOAD if op[2]=0, else EXEC.
REQ-013 DEREF SHALL assert mem_req and rdm; on ack it SHALL pulse wrx; next state is LOAD if op[2]=0, else EXEC.
REQ-014 LOAD SHALL assert mem_req and rdm; on ack it SHALL pulse wrx, clear bit_cnt to 0 and enter ALU.
REQ-015 ALU SHALL assert shift_en and wra every cycle for exactly WIDTH cycles, with bit_cnt counting 0..WIDTH-1; it SHALL NOT assert mem_req.
REQ-016 On the ALU cycle with bit_cnt=WIDTH-1, the block SHALL pulse wrf, wrap bit_cnt to 0 and enter FETCH.
REQ-017 fout SHALL be driven in the wrf cycle as follows: op 000 (ld) and 001 (nor) give 1; 010 (add) gives alu_cout; 011 (shr) gives x0.
REQ-018 EXEC op 101 (st) SHALL assert mem_req and rda; on ack it SHALL pulse wrm and enter FETCH.
REQ-019 EXEC op 110 (jmp) SHALL pulse wrp for one cycle and then enter FETCH.
REQ-020 EXEC op 111 (jnf) SHALL pulse wrp only if f=0, taking one cycle, then enter FETCH.
REQ-021 EXEC op 100 (reserved) SHALL be a one-cycle no-op and then enter FETCH.
REQ-022 All strobes SHALL be combinational from the current state, op and mem_ack; the state, op and bit_cnt registers SHALL be the only flops besides the option in REQ-040.
REQ-023 Outputs SHALL be glitch-free in the sense that at most one of rdp/rdm/rda is high in any cycle.

Reset
REQ-030 While rst_n=0, every output SHALL be 0, including mem_req and state.
REQ-031 Reset SHALL set state=FETCH, bit_cnt=0, op=000 and deref=0.
REQ-032 A reset asserted mid-access or mid-ALU SHALL abandon the operation with no strobe issued; the first cycle after release SHALL be FETCH with mem_req=1.

Configuration
REQ-040 With Q2_SEQ_STEP_EN defined, the block SHALL add inputs run and step (1 bit each); when run=0, FETCH SHALL hold mem_req low until a rising edge of step is detected (one registered step bit), then perform exactly one instruction.
REQ-041 Without Q2_SEQ_STEP_EN, the run and step ports SHALL be absent and FETCH SHALL request immediately.

Structure
REQ-050 Package q2_pkg SHALL hold the state encoding typedef and the opcode constants OP_LD..OP_JNF.
REQ-051 The bit counter with its terminal-count flag SHALL be sub-module q2_bitcnt, parametrised by WIDTH.

Verification
REQ-060 Reset release, then ld with zero-wait ack: FETCH(1 cycle) -> LOAD(1) -> ALU (8 cycles) -> FETCH, with wrf=1 and fout=1 on bit_cnt=7.
REQ-061 add with alu_cout=1 on the last bit, WIDTH=4: exactly 4 shift_en cycles, and wrf with fout=1.
REQ-062 Indirect st (deref=1) with mem_ack delayed 3 cycles per access: mem_req stays high through the wait, and the sequence is wro, wrx, then wrm, each a single pulse.
REQ-063 jnf with f=1 gives no wrp; jnf with f=0 gives one wrp pulse; each takes 1 EXEC cycle.
REQ-064 rst_n pulled low at ALU bit_cnt=3: all outputs 0 during reset, no wrf, and FETCH on release.
REQ-065 With Q2_SEQ_STEP_EN and run=0: no mem_req until a step pulse; one pulse gives exactly one instruction.
